zoom2x_fill: RTL
================

Name: zoom2x_fill

Overview:
- Upstream stage of the display path: builds the 320x240 zoomed frame in the display frame RAM, which the VGA readout stage then scans.
- Reads a 160x120 8-bit source image from a 16-bit source RAM, two pixels per word, high byte = left pixel.
- Writes a 2x nearest-neighbour (pixel-replicated) image into the frame RAM in the same packing.
- One start pulse triggers one full-frame pass.

Parameters:
- SRC_W, 160, source width in pixels; even.
- SRC_H, 120, source height in lines.
- ADDR_W, 16, address width of both RAM ports.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request to begin a pass; sampled only in IDLE.
- busy  out  1  high while a pass is in progress.
- done  out  1  one-cycle pulse after the final write of a pass.
- src_addr  out  ADDR_W  source RAM word address.
- src_rden  out  1  source RAM read enable.
- src_q  in  16  source RAM data, valid the cycle after src_addr/src_rden are presented (registered address, unregistered q).
- dst_addr  out  ADDR_W  frame RAM word address.
- dst_data  out  16  frame RAM write data.
- dst_wren  out  1  frame RAM write enable.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, src_rden=0, dst_wren=0, src_addr=0, dst_addr=0, dst_data=0; all counters cleared.
- Derived values: SW=SRC_W/2 source words per line (80); DW=SRC_W destination words per line (160); DH=2*SRC_H destination lines (240).
- FSM states:
  - IDLE: start=1 -> READ, with row r=0, word w=0. start is ignored in every other state.
  - READ: src_addr = (r>>1)*SW + w, src_rden=1, dst_wren=0 -> WR_HI.
  - WR_HI: src_q is valid. dst_addr = r*DW + 2w, dst_data = {src_q[15:8], src_q[15:8]}, dst_wren=1. Latch src_q[7:0] into lo_reg -> WR_LO.
  - WR_LO: dst_addr = r*DW + 2w + 1, dst_data = {lo_reg, lo_reg}, dst_wren=1.
    - w<SW-1: w++ -> READ.
    - else if r<DH-1: w=0, r++ -> READ.
    - else -> FIN.
  - FIN: done=1 for exactly this cycle, busy=0, dst_wren=0 -> IDLE.
- Outputs (src_addr, src_rden, dst_addr, dst_data, dst_wren) are registered for the state they are listed under, i.e. valid during that state's cycle.
- busy=1 in READ, WR_HI and WR_LO only.
- Address generation:
  - Use running base registers (src_base += SW after every odd r; dst_base += DW after every r). No multipliers.
  - Widths: ADDR_W, no overflow for the default sizes (max dst address 38399).
- Each source line is read twice, once per destination line pair, so vertical replication needs no line buffer.
- Timing:
  - start accepted at cycle 0; first READ at cycle 1.
  - 3 cycles per source word; total busy = DH*SW*3 = 57600 cycles.
  - done asserted at cycle 57601.
- src_rden=0 and dst_wren=0 whenever busy=0.
- Boundaries:
  - Reset mid-pass: return to IDLE next cycle. No further writes, no done pulse. Frame RAM keeps partial contents.
  - start coincident with reset: reset wins, start is lost.
  - start in the FIN cycle: ignored.
  - start in the IDLE cycle following FIN: accepted.

Decomposition:
- Shared package holds display geometry constants: SRC_W=160, SRC_H=120, display window 320x240, window origin (160,120), WORDS_PER_FRAME=38400.
- Shared package also holds the FSM state enum.
- No sub-module. Address counters and FSM fit in one module (~150 lines).

Test Plan:
- Source word 0 = 16'hA15B, rest 0; start -> dst words 0 and 160 = 16'hA1A1; words 1 and 161 = 16'h5B5B; all other written words = 0.
- Incrementing pattern src[i]=i -> dst word (2y)*160+2w and (2y+1)*160+2w = {hi(src[y*80+w]) x2}; +1 words carry the low byte; every address 0..38399 written exactly once; highest written address = 38399.
- Cycle count: start at cycle 0 -> first src_rden at cycle 1, busy high exactly 57600 cycles, single done pulse at cycle 57601, no dst_wren after it.
- start pulsed at cycles 10 and 30000 during a pass -> ignored; exactly one done; total write count 38400.
- reset asserted at cycle 1000 mid-pass -> busy=0 and dst_wren=0 next cycle, no done; a new start afterwards yields a full correct frame.
- Back-to-back: start in the cycle after done -> second pass begins, output identical to the first.

Source files
------------

// File: rtl/zoom2x_fill_pkg.sv
// Display geometry shared by the frame-fill and VGA readout stages, plus the fill FSM states.
package zoom2x_fill_pkg;

  localparam int unsigned FRAME_SRC_W     = 160;
  localparam int unsigned FRAME_SRC_H     = 120;
  localparam int unsigned FRAME_ADDR_W    = 16;
  localparam int unsigned DISP_W          = 320;
  localparam int unsigned DISP_H          = 240;
  localparam int unsigned WIN_X0          = 160;
  localparam int unsigned WIN_Y0          = 120;
  localparam int unsigned WORDS_PER_FRAME = 38400;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WR_HI = 3'd2,
    ST_WR_LO = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/zoom2x_fill_if.sv
// Control handshake plus source-RAM read port and frame-RAM write port of the 2x fill stage.
interface zoom2x_fill_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] src_addr;
  logic              src_rden;
  logic [15:0]       src_q;
  logic [ADDR_W-1:0] dst_addr;
  logic [15:0]       dst_data;
  logic              dst_wren;

  modport master (
    input  start, src_q,
    output busy, done, src_addr, src_rden, dst_addr, dst_data, dst_wren
  );

  modport slave (
    output start, src_q,
    input  busy, done, src_addr, src_rden, dst_addr, dst_data, dst_wren
  );
endinterface

// File: rtl/zoom2x_fill.sv
// Fills the frame RAM with a 2x pixel-replicated copy of the source image, one pass per start.
// Each source word costs three cycles: read, write high-pixel pair, write low-pixel pair.
module zoom2x_fill
  import zoom2x_fill_pkg::*;
#(
  parameter int unsigned SRC_W  = FRAME_SRC_W,
  parameter int unsigned SRC_H  = FRAME_SRC_H,
  parameter int unsigned ADDR_W = FRAME_ADDR_W
) (
  input  logic          clock,
  input  logic          reset,
  zoom2x_fill_if.master bus
);

  localparam int unsigned SW  = SRC_W / 2;
  localparam int unsigned DW  = SRC_W;
  localparam int unsigned DH  = 2 * SRC_H;
  localparam int unsigned W_W = (SW > 1) ? $clog2(SW) : 1;
  localparam int unsigned R_W = (DH > 1) ? $clog2(DH) : 1;

  state_e            state_q, state_d;
  logic [R_W-1:0]    r_q, r_d;
  logic [W_W-1:0]    w_q, w_d;
  logic [ADDR_W-1:0] src_base_q, src_base_d;
  logic [ADDR_W-1:0] dst_base_q, dst_base_d;
  logic [7:0]        lo_q, lo_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic              src_rden_q, src_rden_d;
  logic              dst_wren_q, dst_wren_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       dst_data_c;

  // Next state plus the registered outputs for the state being entered.
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    w_d        = w_q;
    src_base_d = src_base_q;
    dst_base_d = dst_base_q;
    lo_d       = lo_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    src_rden_d = 1'b0;
    dst_wren_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_READ;
          r_d        = '0;
          w_d        = '0;
          src_base_d = '0;
          dst_base_d = '0;
          src_addr_d = '0;
          src_rden_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_READ: begin
        state_d    = ST_WR_HI;
        dst_addr_d = dst_base_q + ADDR_W'({w_q, 1'b0});
        dst_wren_d = 1'b1;
        busy_d     = 1'b1;
      end
      ST_WR_HI: begin
        state_d    = ST_WR_LO;
        lo_d       = bus.src_q[7:0];
        dst_addr_d = dst_addr_q + ADDR_W'(1);
        dst_wren_d = 1'b1;
        busy_d     = 1'b1;
      end
      ST_WR_LO: begin
        if (w_q != W_W'(SW - 1)) begin
          state_d    = ST_READ;
          w_d        = w_q + W_W'(1);
          src_addr_d = src_base_q + ADDR_W'(w_d);
          src_rden_d = 1'b1;
          busy_d     = 1'b1;
        end else if (r_q != R_W'(DH - 1)) begin
          // Each source line feeds two destination lines, so its base moves after odd rows only.
          state_d    = ST_READ;
          w_d        = '0;
          r_d        = r_q + R_W'(1);
          dst_base_d = dst_base_q + ADDR_W'(DW);
          if (r_q[0]) begin
            src_base_d = src_base_q + ADDR_W'(SW);
          end
          src_addr_d = src_base_d;
          src_rden_d = 1'b1;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // src_q is only valid in WR_HI, so the write data is steered straight from it.
  always_comb begin
    dst_data_c = '0;
    unique case (state_q)
      ST_WR_HI: dst_data_c = {bus.src_q[15:8], bus.src_q[15:8]};
      ST_WR_LO: dst_data_c = {lo_q, lo_q};
      default:  dst_data_c = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      r_q        <= '0;
      w_q        <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      lo_q       <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      src_rden_q <= 1'b0;
      dst_wren_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      w_q        <= w_d;
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      lo_q       <= lo_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      src_rden_q <= src_rden_d;
      dst_wren_q <= dst_wren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.src_addr = src_addr_q;
  assign bus.src_rden = src_rden_q;
  assign bus.dst_addr = dst_addr_q;
  assign bus.dst_wren = dst_wren_q;
  assign bus.dst_data = dst_data_c;

endmodule
